result_unloader: RTL and testbench

Downstream stage of the matrix processor. After the processor has written the result matrix D back into the data RAM, this block reads it out in address order (column by column, as the processor writes it) and streams it out one byte per cycle on a valid/ready interface. Back-pressure is absorbed by a small prefetch FIFO that hides the 1-cycle RAM read latency. The block shares the RAM port with the processor; external muxing grants it the port while `busy` is high.

---
 rtl/result_unloader_if.sv | 26 ++
 rtl/result_unloader.sv | 125 ++++++++++++
 tb/tb_result_unloader.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/result_unloader_if.sv
// Byte stream carrying the unloaded result matrix, one element per transfer.
// Handshake: a transfer happens on a rising edge where m_valid && m_ready; once
// m_valid is high it stays high, with m_data/m_eol/m_last stable, until that edge.
interface result_unloader_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_eol;
  logic       m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_eol,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_eol,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/result_unloader.sv
// Reads result matrix D out of the shared data RAM in address order and streams it
// one byte per cycle, using a small prefetch FIFO to cover the 1-cycle read latency.
module result_unloader #(
  parameter int MATRIX_WIDTH = 8,
  parameter int BASE_ADDR    = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    ram_csb,
  output logic                    ram_web,
  output logic [6:0]              ram_addr,
  input  logic [7:0]              ram_din,
  result_unloader_if.master       m,
  output logic [1:0]              fsm_state
);

  localparam int N   = MATRIX_WIDTH * MATRIX_WIDTH;
  localparam int CW  = $clog2(N + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int OW  = $clog2(FIFO_DEPTH + 1);
  localparam int CLW = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]     state;
  logic [CW-1:0]  issue_cnt;
  logic [CW-1:0]  pop_cnt;
  logic [CLW-1:0] col_cnt;
  logic [6:0]     addr_q;
  logic           inflight;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [OW-1:0]  occ;

  logic empty;
  logic issue;
  logic push;
  logic pop;
  logic last_head;
  logic eol_head;

  // A read is only issued when its data is guaranteed a FIFO slot on arrival.
  assign empty     = (occ == '0);
  assign issue     = (state == S_RUN) && ((occ + OW'(inflight)) < OW'(FIFO_DEPTH));
  assign push      = inflight;
  assign pop       = !empty && m.m_ready;
  assign last_head = (pop_cnt == CW'(N - 1));
  assign eol_head  = (col_cnt == CLW'(MATRIX_WIDTH - 1));

  assign ram_csb   = !issue;
  assign ram_web   = 1'b1;
  assign ram_addr  = issue ? addr_q : 7'd0;

  assign m.m_valid = !empty;
  assign m.m_data  = empty ? 8'd0 : mem[rd_ptr];
  assign m.m_eol   = !empty && eol_head;
  assign m.m_last  = !empty && last_head;

  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      issue_cnt <= '0;
      pop_cnt   <= '0;
      col_cnt   <= '0;
      addr_q    <= 7'(BASE_ADDR);
      inflight  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_RUN;
            issue_cnt <= '0;
            pop_cnt   <= '0;
            col_cnt   <= '0;
            addr_q    <= 7'(BASE_ADDR);
            inflight  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
          end
        end
        S_RUN:   if (issue && (issue_cnt == CW'(N - 1))) state <= S_DRAIN;
        S_DRAIN: if (pop && last_head) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (state != S_IDLE) begin
        inflight <= issue;
        if (issue) begin
          issue_cnt <= issue_cnt + 1'b1;
          addr_q    <= addr_q + 7'd1;
        end
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          rd_ptr  <= rd_ptr + 1'b1;
          pop_cnt <= pop_cnt + 1'b1;
          col_cnt <= eol_head ? '0 : col_cnt + 1'b1;
        end
        occ <= occ + OW'(push) - OW'(pop);
      end
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (rst && push) mem[wr_ptr] <= ram_din;
  end

endmodule

// File: tb/tb_result_unloader.sv
// Bench for result_unloader: two instances (base 0 and base 100) share stimulus and
// are checked against a queue model built from RAM contents and the stream rules.
module tb_result_unloader;

  localparam int N  = 64;
  localparam int MW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic rdy = 1'b0;

  logic       busy_a, done_a, csb_a, web_a;
  logic [6:0] addr_a;
  logic [7:0] din_a = 8'd0;
  logic [1:0] st_a;
  logic       busy_b, done_b, csb_b, web_b;
  logic [6:0] addr_b;
  logic [7:0] din_b = 8'd0;
  logic [1:0] st_b;

  logic [7:0] ram [128];

  result_unloader_if ifa ();
  result_unloader_if ifb ();
  assign ifa.m_ready = rdy;
  assign ifb.m_ready = rdy;

  result_unloader #(.MATRIX_WIDTH(MW), .BASE_ADDR(0), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .start(start), .busy(busy_a), .done(done_a),
    .ram_csb(csb_a), .ram_web(web_a), .ram_addr(addr_a), .ram_din(din_a),
    .m(ifa), .fsm_state(st_a)
  );

  result_unloader #(.MATRIX_WIDTH(MW), .BASE_ADDR(100), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .start(start), .busy(busy_b), .done(done_b),
    .ram_csb(csb_b), .ram_web(web_b), .ram_addr(addr_b), .ram_din(din_b),
    .m(ifb), .fsm_state(st_b)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, got running expected finished");
    $fatal(1);
  end

  // synchronous-read RAM model, one read port per instance
  always @(posedge clk) begin
    if (!csb_a) din_a <= ram[addr_a];
    if (!csb_b) din_b <= ram[addr_b];
  end

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q0[$];
  logic [9:0] exp_q1[$];
  int base [2] = '{0, 100};
  int iss [2];
  int popn [2];
  int last_hs [2];
  int done_n [2];
  bit stall_prev [2];
  logic [9:0] prev_v [2];
  int strict;

  typedef struct {
    int mode;
    int exp_done;
    int exp_reads20;
    bit spurious;
  } scn_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic init_model();
    exp_q0.delete();
    exp_q1.delete();
    for (int i = 0; i < N; i++) begin
      exp_q0.push_back({(i == N - 1), (i % MW == MW - 1), ram[(base[0] + i) % 128]});
      exp_q1.push_back({(i == N - 1), (i % MW == MW - 1), ram[(base[1] + i) % 128]});
    end
    for (int k = 0; k < 2; k++) begin
      iss[k] = 0;
      popn[k] = 0;
      last_hs[k] = -1;
      done_n[k] = 0;
      stall_prev[k] = 1'b0;
      prev_v[k] = '0;
    end
  endtask

  task automatic check_cycle(input int k, input int cyc, input logic valid, input logic [7:0] data,
                             input logic eol, input logic last, input logic csb, input logic [6:0] addr,
                             input logic busy, input logic done, input logic web);
    logic [9:0] got;
    logic [9:0] e;
    bit empty_q;
    got = {last, eol, data};
    chk("busy", busy, (cyc >= 1) && (last_hs[k] < 0 || cyc <= last_hs[k]));
    chk("done", done, (last_hs[k] >= 0) && (cyc == last_hs[k] + 1));
    chk("web", web, 1);
    if (done) done_n[k]++;
    if (cyc == 1 || cyc == 2) chk("valid_early", valid, 0);
    if (cyc == 3) chk("valid_first", valid, 1);
    if (!csb) begin
      chk("addr", addr, (base[k] + iss[k]) % 128);
      iss[k]++;
      chk("reads_le_n", iss[k] <= N, 1);
    end
    chk("outstanding_le4", (iss[k] - popn[k]) <= 4, 1);
    if (stall_prev[k]) begin
      chk("stall_valid", valid, 1);
      chk("stall_hold", got, prev_v[k]);
    end
    if (valid && rdy) begin
      empty_q = (k == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
      checks++;
      if (empty_q) begin
        errors++;
        $display("FAIL extra_byte: got byte %0d expected none", data);
      end else begin
        e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL stream[%0d] inst %0d: got %h expected %h", popn[k], k, got, e);
        end
        if (strict != 0) chk("latency", cyc, 3 + popn[k]);
        popn[k]++;
        if (popn[k] == N) last_hs[k] = cyc;
      end
    end
    stall_prev[k] = valid && !rdy;
    prev_v[k] = got;
  endtask

  task automatic drive(input int mode, input int cyc);
    case (mode)
      0: rdy = 1'b1;
      1: rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
      2: rdy = (cyc >= 20);
      default: rdy = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic sample_both(input int cyc);
    check_cycle(0, cyc, ifa.m_valid, ifa.m_data, ifa.m_eol, ifa.m_last, csb_a, addr_a, busy_a, done_a, web_a);
    check_cycle(1, cyc, ifb.m_valid, ifb.m_data, ifb.m_eol, ifb.m_last, csb_b, addr_b, busy_b, done_b, web_b);
  endtask

  task automatic chk_reset(input logic busy, input logic done, input logic csb, input logic web,
                           input logic [6:0] addr, input logic valid, input logic [7:0] data,
                           input logic eol, input logic last, input logic [1:0] st);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_csb", csb, 1);
    chk("rst_web", web, 1);
    chk("rst_addr", addr, 0);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_eol", eol, 0);
    chk("rst_last", last, 0);
    chk("rst_state", st, 0);
  endtask

  task automatic reset_check_both();
    chk_reset(busy_a, done_a, csb_a, web_a, addr_a, ifa.m_valid, ifa.m_data, ifa.m_eol, ifa.m_last, st_a);
    chk_reset(busy_b, done_b, csb_b, web_b, addr_b, ifb.m_valid, ifb.m_data, ifb.m_eol, ifb.m_last, st_b);
  endtask

  // driver task: one full unload with the given ready pattern
  task automatic run_scn(input scn_t s);
    bit finished;
    int hi;
    finished = 1'b0;
    init_model();
    strict = (s.mode == 0) ? 1 : 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      drive(s.mode, cyc);
      start = (cyc == 0) ||
              (s.spurious && (cyc == 10 || (last_hs[0] >= 0 && cyc == last_hs[0] + 1)));
      sample_both(cyc);
      if (cyc == 20 && s.exp_reads20 >= 0) begin
        chk("reads_at_stall", iss[0], s.exp_reads20);
        chk("reads_at_stall_b", iss[1], s.exp_reads20);
      end
      hi = (last_hs[0] > last_hs[1]) ? last_hs[0] : last_hs[1];
      if (last_hs[0] >= 0 && last_hs[1] >= 0 && cyc >= hi + 6) begin
        finished = 1'b1;
        break;
      end
    end
    start = 1'b0;
    rdy = 1'b0;
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL timeout mode %0d: got %0d bytes expected %0d", s.mode, popn[0], N);
    end
    for (int k = 0; k < 2; k++) begin
      chk("bytes_all", popn[k], N);
      chk("reads_total", iss[k], N);
      chk("done_count", done_n[k], 1);
      if (s.exp_done >= 0) chk("done_cycle", last_hs[k] + 1, s.exp_done);
    end
  endtask

  scn_t tbl [5];

  initial begin
    tbl[0] = '{mode: 0, exp_done: 67, exp_reads20: -1, spurious: 1'b0};
    tbl[1] = '{mode: 1, exp_done: -1, exp_reads20: -1, spurious: 1'b0};
    tbl[2] = '{mode: 2, exp_done: 84, exp_reads20: 4,  spurious: 1'b0};
    tbl[3] = '{mode: 0, exp_done: 67, exp_reads20: -1, spurious: 1'b1};
    tbl[4] = '{mode: 3, exp_done: -1, exp_reads20: -1, spurious: 1'b0};

    for (int a = 0; a < 128; a++) ram[a] = 8'(a + 1);

    rst = 1'b0;
    repeat (3) @(negedge clk);
    reset_check_both();
    rst = 1'b1;

    for (int t = 0; t < 5; t++) begin
      if (tbl[t].mode == 3)
        for (int a = 0; a < 128; a++) ram[a] = 8'($urandom_range(0, 255));
      run_scn(tbl[t]);
    end

    // reset in the middle of a transfer, then a clean restart
    for (int a = 0; a < 128; a++) ram[a] = 8'(a + 1);
    init_model();
    strict = 1;
    for (int cyc = 0; cyc <= 30; cyc++) begin
      @(negedge clk);
      rdy = 1'b1;
      start = (cyc == 0);
      sample_both(cyc);
      if (cyc == 30) begin
        chk("midrst_inflight", csb_a, 0);
        chk("midrst_fifo", ifa.m_valid, 1);
        rst = 1'b0;
      end
    end
    @(negedge clk);
    reset_check_both();
    rst = 1'b1;
    rdy = 1'b0;
    start = 1'b0;
    run_scn(tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
